// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt source side of the INT/NMI/INTD interface.
// The CPU controller uses the same state, cfgAddr and INA encodings.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_t;

  localparam logic CFG_ADDR_MASK   = 1'b0;
  localparam logic CFG_ADDR_ENABLE = 1'b1;

  localparam logic INA_INT = 1'b1;
  localparam logic INA_NMI = 1'b0;

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_priority_encoder #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-captures device and NMI requests, prioritises the
// maskable ones and runs the INT handshake (request, acknowledge, end-of-interrupt).
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irqSrc,
  input  logic               nmiSrc,
  input  logic               cfgWrite,
  input  logic               cfgAddr,
  input  logic [NUM_SRC-1:0] cfgWriteData,
  input  logic               eoi,
  input  logic               isInterrupted,
  input  logic               INA,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [ID_W-1:0]    vectorId,
  output logic               inService
);

  logic [NUM_SRC-1:0] irq_hist_reg;
  logic               nmi_hist_reg;
  logic               ack_hist_reg;
  logic               armed_reg;
  logic [NUM_SRC-1:0] pending_reg;
  logic [NUM_SRC-1:0] pending_next;
  logic               nmi_pending_reg;
  logic               nmi_pending_next;
  logic               nmi_reg;
  logic [NUM_SRC-1:0] mask_reg;
  logic               global_enable_reg;
  int_state_t         state_reg;
  logic               int_reg;
  logic               in_service_reg;
  logic [ID_W-1:0]    vector_id_reg;

  logic [NUM_SRC-1:0] irq_rise;
  logic               nmi_rise;
  logic               ack_rise;
  logic               cand_valid;
  logic [ID_W-1:0]    cand_id;
  logic               req_ok;
  logic               int_take;
  logic               nmi_take;
  logic [NUM_SRC-1:0] take_onehot;

  irq_priority_encoder #(
    .NUM_SRC(NUM_SRC),
    .ID_W   (ID_W)
  ) u_prio (
    .req  (pending_reg & mask_reg),
    .valid(cand_valid),
    .id   (cand_id)
  );

  // Edge detection is suppressed on the first cycle after reset so a line that
  // was already high does not look like a fresh 0->1 transition.
  always_comb begin
    irq_rise = armed_reg ? (irqSrc & ~irq_hist_reg) : '0;
    nmi_rise = armed_reg & nmiSrc & ~nmi_hist_reg;
    ack_rise = armed_reg & isInterrupted & ~ack_hist_reg;
  end

  // Decode acknowledges and build next pending state; a new edge beats a clear.
  always_comb begin
    req_ok      = cand_valid & global_enable_reg;
    int_take    = (state_reg == ST_REQ) & ack_rise & (INA == INA_INT) & req_ok;
    nmi_take    = ack_rise & (INA == INA_NMI) & nmi_pending_reg;
    take_onehot = '0;
    if (int_take) take_onehot[cand_id] = 1'b1;
    pending_next     = (pending_reg & ~take_onehot) | irq_rise;
    nmi_pending_next = (nmi_pending_reg & ~nmi_take) | nmi_rise;
  end

  // Input history, pending capture, NMI output and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_hist_reg      <= '0;
      nmi_hist_reg      <= 1'b0;
      ack_hist_reg      <= 1'b0;
      armed_reg         <= 1'b0;
      pending_reg       <= '0;
      nmi_pending_reg   <= 1'b0;
      nmi_reg           <= 1'b0;
      mask_reg          <= '0;
      global_enable_reg <= 1'b0;
    end else begin
      irq_hist_reg    <= irqSrc;
      nmi_hist_reg    <= nmiSrc;
      ack_hist_reg    <= isInterrupted;
      armed_reg       <= 1'b1;
      pending_reg     <= pending_next;
      nmi_pending_reg <= nmi_pending_next;
      nmi_reg         <= nmi_pending_reg & ~nmi_take;
      if (cfgWrite) begin
        if (cfgAddr == CFG_ADDR_MASK) mask_reg <= cfgWriteData;
        else                          global_enable_reg <= cfgWriteData[0];
      end
    end
  end

  // INT handshake FSM with registered INT, inService and vectorId.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      int_reg        <= 1'b0;
      in_service_reg <= 1'b0;
      vector_id_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_ok) begin
            state_reg <= ST_REQ;
            int_reg   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (int_take) begin
            vector_id_reg  <= cand_id;
            int_reg        <= 1'b0;
            in_service_reg <= 1'b1;
            state_reg      <= ST_SERVICE;
          end else if (!req_ok) begin
            int_reg   <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (eoi) begin
            in_service_reg <= 1'b0;
            state_reg      <= ST_IDLE;
          end
        end
        default: begin
          int_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign INT       = int_reg;
  assign NMI       = nmi_reg;
  assign INTD      = ~global_enable_reg;
  assign vectorId  = vector_id_reg;
  assign inService = in_service_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] irqSrc;
  logic               nmiSrc;
  logic               cfgWrite;
  logic               cfgAddr;
  logic [NUM_SRC-1:0] cfgWriteData;
  logic               eoi;
  logic               isInterrupted;
  logic               INA;
  logic               INT;
  logic               NMI;
  logic               INTD;
  logic [ID_W-1:0]    vectorId;
  logic               inService;

  int n_compared;
  int n_mismatched;

  interrupt_controller #(
    .NUM_SRC(NUM_SRC),
    .ID_W   (ID_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irqSrc       (irqSrc),
    .nmiSrc       (nmiSrc),
    .cfgWrite     (cfgWrite),
    .cfgAddr      (cfgAddr),
    .cfgWriteData (cfgWriteData),
    .eoi          (eoi),
    .isInterrupted(isInterrupted),
    .INA          (INA),
    .INT          (INT),
    .NMI          (NMI),
    .INTD         (INTD),
    .vectorId     (vectorId),
    .inService    (inService)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic addr, input logic [NUM_SRC-1:0] data);
    cfgWrite     = 1'b1;
    cfgAddr      = addr;
    cfgWriteData = data;
    tick();
    cfgWrite     = 1'b0;
  endtask

  // Drive source high for one cycle; pending is captured at that edge.
  task automatic pulse_irq(input logic [NUM_SRC-1:0] bits);
    irqSrc = bits;
    tick();
    irqSrc = '0;
  endtask

  // Raise the acknowledge for one cycle; outputs reflect it after the edge.
  task automatic ack(input logic ina);
    isInterrupted = 1'b1;
    INA           = ina;
    tick();
    isInterrupted = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_INT"},       32'(INT),       32'd0);
    check_val({pfx, "_NMI"},       32'(NMI),       32'd0);
    check_val({pfx, "_INTD"},      32'(INTD),      32'd1);
    check_val({pfx, "_vectorId"},  32'(vectorId),  32'd0);
    check_val({pfx, "_inService"}, 32'(inService), 32'd0);
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    rst           = 1'b1;
    irqSrc        = '0;
    nmiSrc        = 1'b0;
    cfgWrite      = 1'b0;
    cfgAddr       = 1'b0;
    cfgWriteData  = '0;
    eoi           = 1'b0;
    isInterrupted = 1'b0;
    INA           = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // 1: single source 5 through the full handshake
    cfg_write(1'b0, 8'hFF);
    cfg_write(1'b1, 8'h01);
    check_val("t1_INTD_enabled", 32'(INTD), 32'd0);
    pulse_irq(8'h20);
    tick();
    check_val("t1_INT_req", 32'(INT), 32'd1);
    ack(1'b1);
    check_val("t1_vectorId", 32'(vectorId), 32'd5);
    check_val("t1_inService", 32'(inService), 32'd1);
    check_val("t1_INT_after_ack", 32'(INT), 32'd0);
    tick();
    do_eoi();
    check_val("t1_inService_eoi", 32'(inService), 32'd0);
    tick();
    check_val("t1_INT_idle", 32'(INT), 32'd0);

    // 2: sources 2 and 6 together, 2 wins then 6 after eoi
    pulse_irq(8'h44);
    tick();
    check_val("t2_INT_req", 32'(INT), 32'd1);
    ack(1'b1);
    check_val("t2_vectorId_first", 32'(vectorId), 32'd2);
    do_eoi();
    tick();
    check_val("t2_INT_reassert", 32'(INT), 32'd1);
    ack(1'b1);
    check_val("t2_vectorId_second", 32'(vectorId), 32'd6);
    do_eoi();

    // 3: NMI during SERVICE with interrupts disabled
    pulse_irq(8'h02);
    tick();
    ack(1'b1);
    check_val("t3_vectorId", 32'(vectorId), 32'd1);
    cfg_write(1'b1, 8'h00);
    nmiSrc = 1'b1;
    tick();
    nmiSrc = 1'b0;
    tick();
    check_val("t3_NMI_req", 32'(NMI), 32'd1);
    check_val("t3_INTD", 32'(INTD), 32'd1);
    ack(1'b0);
    tick();
    check_val("t3_NMI_cleared", 32'(NMI), 32'd0);
    check_val("t3_inService_kept", 32'(inService), 32'd1);
    check_val("t3_vectorId_kept", 32'(vectorId), 32'd1);
    do_eoi();
    cfg_write(1'b1, 8'h01);
    tick();

    // 4: masked source re-requests once unmasked
    cfg_write(1'b0, 8'h00);
    pulse_irq(8'h08);
    tick();
    check_val("t4_INT_masked_a", 32'(INT), 32'd0);
    tick();
    check_val("t4_INT_masked_b", 32'(INT), 32'd0);
    cfg_write(1'b0, 8'h08);
    tick();
    check_val("t4_INT_unmasked", 32'(INT), 32'd1);
    ack(1'b1);
    check_val("t4_vectorId", 32'(vectorId), 32'd3);
    do_eoi();
    cfg_write(1'b0, 8'hFF);

    // 5: disable while in REQ drops INT but keeps pending
    pulse_irq(8'h10);
    tick();
    check_val("t5_INT_req", 32'(INT), 32'd1);
    cfg_write(1'b1, 8'h00);
    tick();
    check_val("t5_INT_dropped", 32'(INT), 32'd0);
    check_val("t5_inService", 32'(inService), 32'd0);
    cfg_write(1'b1, 8'h01);
    tick();
    check_val("t5_INT_pending_kept", 32'(INT), 32'd1);
    ack(1'b1);
    check_val("t5_vectorId", 32'(vectorId), 32'd4);
    do_eoi();

    // 7: stray ack in IDLE and stray eoi are ignored
    ack(1'b1);
    check_val("t7_stray_ack_inService", 32'(inService), 32'd0);
    check_val("t7_stray_ack_vectorId", 32'(vectorId), 32'd4);
    do_eoi();
    check_val("t7_stray_eoi_INT", 32'(INT), 32'd0);

    // 6: reset during SERVICE with a source held high
    pulse_irq(8'h01);
    tick();
    ack(1'b1);
    check_val("t6_vectorId_pre", 32'(vectorId), 32'd0);
    check_val("t6_inService_pre", 32'(inService), 32'd1);
    irqSrc = 8'h04;
    tick();
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("t6_reset");
    rst = 1'b0;
    tick();
    cfg_write(1'b0, 8'hFF);
    cfg_write(1'b1, 8'h01);
    tick();
    tick();
    check_val("t6_held_no_INT", 32'(INT), 32'd0);
    irqSrc = 8'h00;
    tick();
    irqSrc = 8'h04;
    tick();
    tick();
    check_val("t6_toggle_INT", 32'(INT), 32'd1);
    ack(1'b1);
    check_val("t6_vectorId", 32'(vectorId), 32'd2);
    irqSrc = 8'h00;
    do_eoi();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
